// File: rtl/video_timing_ctrl.sv
// Raster timing generator for the HDMI output path: registered sync/de,
// a one-cycle-early pixel fetch request with coordinates, and frame-gated start/stop.
module video_timing_ctrl #(
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter logic SYNC_ACT = 1'b1,
  parameter int   CNT_W    = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             pix_req,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             busy
);

  localparam int HA = H_SYNC + H_BP;
  localparam int VA = V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] HLast  = CNT_W'(HA + H_ACTIVE + H_FP - 1);
  localparam logic [CNT_W-1:0] VLast  = CNT_W'(VA + V_ACTIVE + V_FP - 1);
  localparam logic [CNT_W-1:0] HSyncE = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VSyncE = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] DeLo   = CNT_W'(HA);
  localparam logic [CNT_W-1:0] DeHi   = CNT_W'(HA + H_ACTIVE);
  localparam logic [CNT_W-1:0] ReqLo  = CNT_W'(HA - 1);
  localparam logic [CNT_W-1:0] ReqHi  = CNT_W'(HA + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] LineLo = CNT_W'(VA);
  localparam logic [CNT_W-1:0] LineHi = CNT_W'(VA + V_ACTIVE);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] p_q, p_d, l_q, l_d;
  logic             run_d, lineAct_d, req_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic             req_q, fs_q, fs_d, busy_q;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;

  // The counters hold the position being shown on the outputs; the outputs
  // are decoded from the next position so they register alongside it.
  always_comb begin
    state_d = state_q;
    p_d     = '0;
    l_d     = '0;
    run_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = RUN;
          run_d   = 1'b1;
        end
      end
      RUN: begin
        if (p_q == HLast && l_q == VLast) begin
          if (enable) run_d = 1'b1;
          else        state_d = IDLE;
        end else if (p_q == HLast) begin
          run_d = 1'b1;
          l_d   = l_q + 1'b1;
        end else begin
          run_d = 1'b1;
          p_d   = p_q + 1'b1;
          l_d   = l_q;
        end
      end
      default: state_d = IDLE;
    endcase

    lineAct_d = run_d && (l_d >= LineLo) && (l_d < LineHi);
    req_d     = lineAct_d && (p_d >= ReqLo) && (p_d < ReqHi);
    de_d      = lineAct_d && (p_d >= DeLo) && (p_d < DeHi);
    hsync_d   = (run_d && p_d < HSyncE) ? SYNC_ACT : ~SYNC_ACT;
    vsync_d   = (run_d && l_d < VSyncE) ? SYNC_ACT : ~SYNC_ACT;
    fs_d      = run_d && (p_d == '0) && (l_d == '0);
    x_d       = req_d ? (p_d - ReqLo) : '0;
    y_d       = req_d ? (l_d - LineLo) : '0;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      l_q     <= '0;
      hsync_q <= ~SYNC_ACT;
      vsync_q <= ~SYNC_ACT;
      de_q    <= 1'b0;
      req_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      l_q     <= l_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      req_q   <= req_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      busy_q  <= run_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign pix_req     = req_q;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Scoreboard bench for video_timing_ctrl on a 10x5 raster: a frame-cycle
// reference model queues the expected outputs, a monitor compares them.
module tb_video_timing_ctrl;

  localparam int H_SYNC = 2, H_BP = 2, H_ACTIVE = 4, H_FP = 2;
  localparam int V_SYNC = 1, V_BP = 1, V_ACTIVE = 2, V_FP = 1;
  localparam int CNT_W = 12;
  localparam int HT = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int VT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int FRAME = HT * VT;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             enable = 1'b0;
  logic             hsync, vsync, de, pix_req, frame_start, busy;
  logic [CNT_W-1:0] pix_x, pix_y;

  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             de;
    logic             req;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             fs;
    logic             busy;
  } obs_t;

  obs_t expQ[$];
  int   checks = 0;
  int   fails = 0;
  bit   modelRun = 0;
  int   modelC = 0;
  int   cycleNo = 0;
  int   reqCount = 0;
  int   deCount = 0;

  video_timing_ctrl #(
    .H_SYNC(H_SYNC), .H_BP(H_BP), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .V_SYNC(V_SYNC), .V_BP(V_BP), .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
    .SYNC_ACT(1'b1), .CNT_W(CNT_W)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable),
    .hsync(hsync), .vsync(vsync), .de(de), .pix_req(pix_req),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Expected outputs for frame cycle c, straight from the raster rules.
  function automatic obs_t expFor(input bit run, input int c);
    obs_t o;
    int p, l;
    bit act;
    o = '0;
    if (run) begin
      p      = c % HT;
      l      = c / HT;
      act    = (l >= V_SYNC + V_BP) && (l < V_SYNC + V_BP + V_ACTIVE);
      o.hs   = (p < H_SYNC);
      o.vs   = (l < V_SYNC);
      o.de   = act && (p >= H_SYNC + H_BP) && (p < H_SYNC + H_BP + H_ACTIVE);
      o.req  = act && (p >= H_SYNC + H_BP - 1) && (p < H_SYNC + H_BP + H_ACTIVE - 1);
      o.x    = o.req ? CNT_W'(p - (H_SYNC + H_BP - 1)) : '0;
      o.y    = o.req ? CNT_W'(l - (V_SYNC + V_BP)) : '0;
      o.fs   = (c == 0);
      o.busy = 1'b1;
    end
    return o;
  endfunction

  function automatic obs_t sampleDut();
    obs_t o;
    o.hs = hsync; o.vs = vsync; o.de = de; o.req = pix_req;
    o.x = pix_x; o.y = pix_y; o.fs = frame_start; o.busy = busy;
    return o;
  endfunction

  task automatic checkOutput(input string name, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got hs=%b vs=%b de=%b req=%b x=%0d y=%0d fs=%b busy=%b, expected hs=%b vs=%b de=%b req=%b x=%0d y=%0d fs=%b busy=%b",
               name, act.hs, act.vs, act.de, act.req, act.x, act.y, act.fs, act.busy,
               exp.hs, exp.vs, exp.de, exp.req, exp.x, exp.y, exp.fs, exp.busy);
    end
  endtask

  // Drive one cycle of inputs at the falling edge and queue the response
  // expected after the following rising edge.
  task automatic applyStimulus(input logic en, input logic rstn);
    @(negedge sys_clk);
    enable    = en;
    sys_rst_n = rstn;
    if (!rstn) begin
      modelRun = 0;
      modelC   = 0;
    end else if (!modelRun) begin
      if (en) begin
        modelRun = 1;
        modelC   = 0;
      end
    end else if (modelC == FRAME - 1) begin
      if (en) modelC = 0;
      else    modelRun = 0;
    end else begin
      modelC++;
    end
    expQ.push_back(expFor(modelRun, modelC));
  endtask

  // Monitor: every cycle presents an output, compared against the queue head.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge sys_clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        a = sampleDut();
        checkOutput($sformatf("cycle%0d", cycleNo), a, e);
        if (e.fs) begin
          reqCount = 0;
          deCount  = 0;
        end
        reqCount += int'(a.req);
        deCount  += int'(a.de);
        if (e.busy && e.x == '0 && !e.req && !e.fs && modelC == FRAME - 1) begin
          checks++;
          if (reqCount != H_ACTIVE * V_ACTIVE || deCount != H_ACTIVE * V_ACTIVE) begin
            fails++;
            $display("[TB] FAIL frame_count: got req=%0d de=%0d, expected %0d each",
                     reqCount, deCount, H_ACTIVE * V_ACTIVE);
          end
        end
      end
      cycleNo++;
    end
  end

  initial begin
    int guard;
    repeat (3) applyStimulus(1'b0, 1'b0);
    repeat (20) applyStimulus(1'b0, 1'b1);

    // Two back-to-back frames, then stop requested at frame cycle 20.
    repeat (2 * FRAME + 5) applyStimulus(1'b1, 1'b1);
    guard = 0;
    while (!(modelRun && modelC == 19) && guard < 200) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    repeat (FRAME + 10) applyStimulus(1'b0, 1'b1);

    // Restart, with a mid-frame enable glitch that must be ignored.
    repeat (15) applyStimulus(1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1);
    repeat (2 * FRAME) applyStimulus(1'b1, 1'b1);

    // Random enable activity.
    for (int i = 0; i < 600; i++)
      applyStimulus(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, 1'b1);

    // Reset mid-frame at p=5, l=2.
    guard = 0;
    while (!(modelRun && modelC == 2 * HT + 5) && guard < 200) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("async_reset", sampleDut(), expFor(1'b0, 0));
    modelRun = 0;
    modelC   = 0;
    repeat (3) applyStimulus(1'b1, 1'b0);
    repeat (FRAME + 5) applyStimulus(1'b1, 1'b1);
    repeat (3) applyStimulus(1'b0, 1'b1);

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(posedge sys_clk);
      guard++;
    end
    @(negedge sys_clk);
    if (expQ.size() > 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
